slave_interface: RTL
====================

SLAVE_INTERFACE -- requirements
Module: slave_interface

Interface
REQ-001 The block SHALL have the parameter SLAVE_ID, default 4'h1, which it SHALL match against addr[15:12] of each frame.
REQ-002 The block SHALL have the parameter DEPTH, default 2048, giving the number of valid local word offsets.
REQ-003 The block SHALL have the parameter TIMEOUT, default 8, giving the maximum number of cycles to wait for a wdata start bit.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port addr, input, 1 bit: serial address bus.
REQ-007 The block SHALL have port wdata, input, 1 bit: serial write-data bus.
REQ-008 The block SHALL have port rdata, output, 1 bit: serial read data, valid only while rdata_en=1.
REQ-009 The block SHALL have port response, output, 2 bits: response code, valid only while resp_en=1.
REQ-010 The block SHALL have port rdata_en, output, 1 bit: enables the external tristate buffer that drives rdata.
REQ-011 The block SHALL have port resp_en, output, 1 bit: enables the external tristate buffer that drives response.
REQ-012 The block SHALL have port mem_addr, output, 12 bits: local word offset, taken from addr[11:0].
REQ-013 The block SHALL have port mem_wdata, output, 8 bits: write data to local storage.
REQ-014 The block SHALL have port mem_wen, output, 1 bit: write request to local storage.
REQ-015 The block SHALL have port mem_ren, output, 1 bit: read request to local storage.
REQ-016 The block SHALL have port mem_rdata, input, 8 bits: read data from local storage.
REQ-017 The block SHALL have port mem_ready, input, 1 bit: local storage completion.

Function
REQ-018 The addr line SHALL be idle at 0; a frame SHALL start with addr=1 (cycle T0), followed by addr[15..0] MSB first (T1-T16), then a mode bit at T17 (1=write, 0=read).
REQ-019 The FSM SHALL have the states IDLE, ADDR, MODE, DECODE, WWAIT, WDATA, MEMWR, MEMRD, RDOUT and RESP, all registered.
REQ-020 At T18 (DECODE): if addr[15:12]!=SLAVE_ID, the block SHALL return to IDLE without driving the bus or touching the memory interface.
REQ-021 At T18 (DECODE): if the slave is selected and addr[11:0]>=DEPTH, the block SHALL go to RESP with code 2'b10 (error) and SHALL NOT access memory.
REQ-022 Selected write: WWAIT SHALL count cycles until wdata=1 (start bit), then WDATA SHALL shift in 8 bits MSB first.
REQ-023 If no wdata start bit arrives within TIMEOUT cycles in WWAIT, the block SHALL go to RESP with code 2'b10.
REQ-024 MEMWR SHALL hold mem_wen=1 with mem_addr and mem_wdata stable until the cycle in which mem_ready=1, then drop mem_wen and go to RESP with code 2'b01.
REQ-025 Selected read: MEMRD SHALL hold mem_ren=1 until mem_ready=1, capturing mem_rdata in that cycle.
REQ-026 RDOUT SHALL drive rdata_en=1 for 9 cycles: a start bit 1, then the 8 data bits MSB first; the block SHALL then go to RESP with code 2'b01.
REQ-027 RESP SHALL drive resp_en=1 with the response code for exactly one cycle, then return to IDLE.
REQ-028 When the corresponding enable is 0, rdata SHALL be 0 and response SHALL be 2'b00.
REQ-029 mem_wen and mem_ren SHALL never be 1 in the same cycle.
REQ-030 Once a frame has started, further addr activity SHALL be ignored until the FSM returns to IDLE; a new start bit in the RESP cycle SHALL be ignored.
REQ-031 A new frame SHALL be accepted from the cycle after RESP (back-to-back transactions permitted).
REQ-032 mem_ready asserted outside MEMWR/MEMRD SHALL be ignored.
REQ-033 The timeout counter SHALL be 8 bits wide and cleared on entry to WWAIT.

Reset
REQ-034 While reset=0, the block SHALL asynchronously force: state=IDLE, shift registers=0, counters=0, rdata=0, response=2'b00, rdata_en=0, resp_en=0, mem_addr=0, mem_wdata=0, mem_wen=0, mem_ren=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no response issued; the first frame SHALL be recognised on a start bit sampled at or after the first rising edge following deassertion.

Verification
REQ-036 Write 0xA5 to address 16'h1003, wdata start at T20, mem_ready 2 cycles after mem_wen -> mem_addr=12'h003, mem_wdata=8'hA5, mem_wen high for 3 cycles, then response=01 with resp_en=1 for 1 cycle.
REQ-037 Read address 16'h1010 with mem_rdata=8'h3C, mem_ready immediate -> rdata serial stream 1,0,0,1,1,1,1,0,0 under rdata_en, then response=01.
REQ-038 Frame to address 16'h2003 with SLAVE_ID=1 -> rdata_en, resp_en, mem_wen and mem_ren all stay 0 and the FSM is in IDLE at T19.
REQ-039 Frame to address 16'h1900 with DEPTH=2048 -> no memory access, response=10 for 1 cycle at T19.
REQ-040 Write with no wdata start bit and TIMEOUT=8 -> response=10 after 8 WWAIT cycles, and mem_wen is never asserted.
REQ-041 Reset pulled low in MEMRD -> all outputs 0 immediately; after release, a read to 16'h1001 completes normally.

Source files
------------

// File: rtl/slave_interface.sv
// ----------------------------------------------------------------------------
// slave_interface
//
// Serial-bus slave. A frame on the one-bit addr line is a start bit (1),
// sixteen address bits MSB first and a mode bit (1 = write, 0 = read).
// addr[15:12] selects the slave and addr[11:0] is the local word offset.
//
// Write transaction:
//   1. Wait for a start bit on wdata. If none arrives within TIMEOUT
//      cycles, respond with an error.
//   2. Shift in eight data bits, MSB first.
//   3. Hold mem_wen until mem_ready is seen.
//   4. Respond OK.
//
// Read transaction:
//   1. Hold mem_ren until mem_ready is seen, capturing mem_rdata.
//   2. Send a start bit and then the eight data bits, MSB first, on rdata
//      under rdata_en.
//   3. Respond OK.
//
// An offset at or beyond DEPTH is answered with an error and never reaches
// the memory. The response code is presented for a single cycle under
// resp_en.
//
// Parameters
//   SLAVE_ID  : 4-bit id matched against addr[15:12]
//   DEPTH     : number of valid local word offsets
//   TIMEOUT   : cycles to wait for the wdata start bit
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   addr      : serial address / mode bus
//   wdata     : serial write-data bus
//   rdata     : serial read data (0 unless rdata_en)
//   response  : response code, 01 = ok, 10 = error (00 unless resp_en)
//   rdata_en  : enable for the external rdata tristate driver
//   resp_en   : enable for the external response tristate driver
//   mem_addr  : local word offset to storage
//   mem_wdata : write data to storage
//   mem_wen   : storage write request
//   mem_ren   : storage read request
//   mem_rdata : read data from storage
//   mem_ready : storage completion, honoured only while a request is held
// ----------------------------------------------------------------------------
module slave_interface #(
    parameter logic [3:0]  SLAVE_ID = 4'h1,
    parameter int unsigned DEPTH    = 2048,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr,
    input  logic        wdata,
    output logic        rdata,
    output logic [1:0]  response,
    output logic        rdata_en,
    output logic        resp_en,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    output logic        mem_ren,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        MODE,
        DECODE,
        WWAIT,
        WDATA,
        MEMWR,
        MEMRD,
        RDOUT,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b10;

    state_t      state;
    logic [15:0] addr_sr;      // received frame address
    logic        write_mode;   // received mode bit
    logic [7:0]  data_sr;      // write data in, read data out
    logic [3:0]  bit_cnt;      // position within address / data / rdout stream
    logic [7:0]  timeout_cnt;  // cycles already spent in WWAIT

    logic selected;
    logic in_range;
    logic timeout_hit;

    always_comb begin
        selected    = (addr_sr[15:12] == SLAVE_ID);
        in_range    = ({20'd0, addr_sr[11:0]} < DEPTH);
        // True in the last permitted WWAIT cycle; TIMEOUT of 0 behaves like 1.
        timeout_hit = (({24'd0, timeout_cnt} + 32'd1) >= TIMEOUT);
    end

    // Single registered FSM. Every output is updated on the same edge as the
    // state transition, so the outputs are clean registers and are valid in
    // the first cycle of the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addr_sr     <= '0;
            write_mode  <= 1'b0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            rdata       <= 1'b0;
            response    <= '0;
            rdata_en    <= 1'b0;
            resp_en     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (addr) begin
                        state   <= ADDR;
                        bit_cnt <= '0;
                    end
                end

                ADDR: begin
                    addr_sr <= {addr_sr[14:0], addr};
                    if (bit_cnt == 4'd15) begin
                        state <= MODE;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                MODE: begin
                    write_mode <= addr;
                    state      <= DECODE;
                end

                DECODE: begin
                    if (!selected) begin
                        // Frame addressed to another slave: stay silent.
                        state <= IDLE;
                    end else if (!in_range) begin
                        state    <= RESP;
                        resp_en  <= 1'b1;
                        response <= RESP_ERR;
                    end else if (write_mode) begin
                        state       <= WWAIT;
                        timeout_cnt <= '0;
                    end else begin
                        state    <= MEMRD;
                        mem_ren  <= 1'b1;
                        mem_addr <= addr_sr[11:0];
                    end
                end

                WWAIT: begin
                    if (wdata) begin
                        state   <= WDATA;
                        bit_cnt <= '0;
                    end else if (timeout_hit) begin
                        state    <= RESP;
                        resp_en  <= 1'b1;
                        response <= RESP_ERR;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end

                WDATA: begin
                    data_sr <= {data_sr[6:0], wdata};
                    if (bit_cnt == 4'd7) begin
                        state     <= MEMWR;
                        mem_wen   <= 1'b1;
                        mem_addr  <= addr_sr[11:0];
                        mem_wdata <= {data_sr[6:0], wdata};
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                MEMWR: begin
                    if (mem_ready) begin
                        mem_wen  <= 1'b0;
                        state    <= RESP;
                        resp_en  <= 1'b1;
                        response <= RESP_OK;
                    end
                end

                MEMRD: begin
                    if (mem_ready) begin
                        mem_ren  <= 1'b0;
                        data_sr  <= mem_rdata;
                        state    <= RDOUT;
                        rdata_en <= 1'b1;
                        rdata    <= 1'b1;  // start bit
                        bit_cnt  <= '0;
                    end
                end

                RDOUT: begin
                    // bit_cnt counts data bits already placed on rdata.
                    if (bit_cnt == 4'd8) begin
                        rdata_en <= 1'b0;
                        rdata    <= 1'b0;
                        state    <= RESP;
                        resp_en  <= 1'b1;
                        response <= RESP_OK;
                    end else begin
                        rdata   <= data_sr[7];
                        data_sr <= {data_sr[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end

                RESP: begin
                    // addr is not looked at here: a start bit in this cycle
                    // is deliberately dropped.
                    resp_en  <= 1'b0;
                    response <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
